// File: rtl/bp_me_wormhole_to_stream_pkg.sv
// Shared types and constant helpers for the wormhole-to-stream receive path.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package bp_me_wormhole_to_stream_pkg;

    typedef enum logic [1:0] {
        e_hdr     = 2'd0,
        e_hdr_out = 2'd1,
        e_data    = 2'd2
    } wh_state_e;

    function automatic int cdiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // A counter for a single element still needs one bit of storage.
    function automatic int clog2_min1(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

endpackage

// File: rtl/bp_me_wormhole_to_stream_sipo.sv
// Serial-in/parallel-out collector: writes each accepted flit into the next header slot.
// Latency: a slot is updated on the clock edge that accepts its flit.
// Backpressure: none; the caller only pulses v_i on accepted flits.
module bp_me_wormhole_to_stream_sipo
    import bp_me_wormhole_to_stream_pkg::*;
#(
    parameter int width_p = 64,
    parameter int els_p   = 2
)
(
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       first_o,
    output logic                       last_o,
    output logic [els_p*width_p-1:0]   data_o
);

    localparam int cnt_w_lp = clog2_min1(els_p);
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(els_p - 1);

    logic [cnt_w_lp-1:0]            cnt_r;
    logic [els_p-1:0][width_p-1:0]  slot_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r  <= '0;
            slot_r <= '0;
        end else if (v_i) begin
            slot_r[cnt_r] <= data_i;
            cnt_r         <= last_o ? '0 : cnt_r + 1'b1;
        end
    end

    assign first_o = (cnt_r == '0);
    assign last_o  = (cnt_r == cnt_max_lp);
    assign data_o  = slot_r;

endmodule

// File: rtl/bp_me_wormhole_to_stream.sv
// Reassembles wormhole header flits and emits one BedRock header beat, then passes data beats through.
// Latency: header beat valid the cycle after the last header flit; data beats are combinational.
// Backpressure: header held until pr handshake; in data phase link ready follows pr_ready_and_i.
module bp_me_wormhole_to_stream
    import bp_me_wormhole_to_stream_pkg::*;
#(
    parameter int flit_width_p       = 64,
    parameter int cord_width_p       = 7,
    parameter int len_width_p        = 4,
    parameter int cid_width_p        = 0,
    parameter int pr_hdr_width_p     = 110,
    parameter int pr_data_width_p    = 64,
    parameter int wh_hdr_width_p     = cord_width_p + len_width_p + cid_width_p + pr_hdr_width_p,
    parameter int wh_pr_hdr_offset_p = cord_width_p + len_width_p + cid_width_p,
    parameter int wh_len_offset_p    = cord_width_p
)
(
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [flit_width_p-1:0]     link_data_i,
    input  logic                        link_v_i,
    output logic                        link_ready_and_o,
    output logic [pr_hdr_width_p-1:0]   pr_hdr_o,
    output logic [pr_data_width_p-1:0]  pr_data_o,
    output logic                        pr_v_o,
    input  logic                        pr_ready_and_i,
    output logic                        pr_last_o
);

    localparam int hdr_len_lp = cdiv(wh_hdr_width_p, flit_width_p);
    localparam int len_ext_w_lp = len_width_p + 1;
    localparam logic [len_ext_w_lp-1:0] hdr_len_c_lp = len_ext_w_lp'(hdr_len_lp);

    if (flit_width_p != pr_data_width_p) begin : g_err_width
        $error("flit_width_p must equal pr_data_width_p");
    end
    if (!is_pow2(flit_width_p) || !is_pow2(pr_data_width_p)) begin : g_err_pow2
        $error("flit and data widths must be powers of 2");
    end
    if (cord_width_p + len_width_p > flit_width_p) begin : g_err_fit
        $error("cord and len fields must fit in the first flit");
    end

    wh_state_e state_r, state_n;
    logic [len_width_p-1:0]               data_rem_r;
    logic [hdr_len_lp*flit_width_p-1:0]   hdr_r;
    logic                                 hdr_v, hdr_first, hdr_last;
    logic                                 data_hs;
    logic [len_width_p-1:0]               len;
    logic [len_ext_w_lp-1:0]              len_plus1, data_rem_ext;
    logic                                 malformed;
    logic [len_width_p-1:0]               data_rem_n;
    logic                                 hdr_unused;

    assign hdr_v   = (state_r == e_hdr) & link_v_i & link_ready_and_o;
    assign data_hs = (state_r == e_data) & link_v_i & pr_ready_and_i;

    bp_me_wormhole_to_stream_sipo #(
        .width_p (flit_width_p),
        .els_p   (hdr_len_lp)
    ) u_hdr_sipo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (hdr_v),
        .data_i    (link_data_i),
        .first_o   (hdr_first),
        .last_o    (hdr_last),
        .data_o    (hdr_r)
    );

    // Remaining data beats come from the total flit count minus the header flits;
    // a length too short to cover the header is treated as a header-only packet.
    assign len          = link_data_i[wh_len_offset_p +: len_width_p];
    assign len_plus1    = {1'b0, len} + 1'b1;
    assign malformed    = (len_plus1 < hdr_len_c_lp);
    assign data_rem_ext = len_plus1 - hdr_len_c_lp;
    assign data_rem_n   = malformed ? '0 : data_rem_ext[len_width_p-1:0];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_hdr;
        end else begin
            state_r <= state_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_rem_r <= '0;
        end else if (hdr_v && hdr_first) begin
            data_rem_r <= data_rem_n;
        end else if (data_hs) begin
            data_rem_r <= data_rem_r - 1'b1;
        end
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_hdr:     if (hdr_v && hdr_last) state_n = e_hdr_out;
            e_hdr_out: if (pr_ready_and_i) state_n = (data_rem_r != '0) ? e_data : e_hdr;
            e_data:    if (data_hs && (data_rem_r == len_width_p'(1))) state_n = e_hdr;
            default:   state_n = e_hdr;
        endcase
    end

    always_comb begin
        link_ready_and_o = 1'b0;
        pr_v_o           = 1'b0;
        pr_data_o        = '0;
        pr_last_o        = 1'b0;
        unique case (state_r)
            e_hdr: begin
                link_ready_and_o = reset_n_i;
            end
            e_hdr_out: begin
                pr_v_o    = 1'b1;
                pr_last_o = (data_rem_r == '0);
            end
            e_data: begin
                pr_v_o           = link_v_i;
                link_ready_and_o = pr_ready_and_i & reset_n_i;
                pr_data_o        = link_data_i;
                pr_last_o        = (data_rem_r == len_width_p'(1));
            end
            default: ;
        endcase
    end

    assign pr_hdr_o   = hdr_r[wh_pr_hdr_offset_p +: pr_hdr_width_p];
    assign hdr_unused = ^hdr_r;

    a_len_ok: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                               (hdr_v && hdr_first) |-> !malformed);

endmodule

// File: doc/bp_me_wormhole_to_stream.md
# bp_me_wormhole_to_stream

Receive-side companion of the BedRock stream-to-wormhole converter. Accepts wormhole link flits, reassembles the multi-flit wormhole header, and extracts the BedRock protocol header. Emits one header beat followed by the packet's data beats on a ready&valid BedRock stream interface. Sits between the wormhole router/concentrator ejection port and the LCE/CCE/memory stream consumers.

## Interface
- flit_width_p, none (required): link flit width; must equal pr_data_width_p, power of 2.
- cord_width_p, none (required): destination coordinate field width.
- len_width_p, none (required): wormhole length field width; len = total flits − 1.
- cid_width_p, 0: concentrator id width.
- pr_hdr_width_p, none (required): protocol header width.
- pr_data_width_p, none (required): protocol data beat width.
- wh_hdr_width_p, cord+len+cid+pr_hdr: total wormhole header width.
- wh_pr_hdr_offset_p, cord+len+cid: bit offset of the protocol header in the deserialized header.
- wh_len_offset_p, cord_width_p: bit offset of the len field.
- hdr_len_lp (localparam): CDIV(wh_hdr_width_p, flit_width_p), header flits per packet.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; asynchronous, active-low.
- link_data_i  in  flit_width_p  incoming flit.
- link_v_i  in  1  flit valid.
- link_ready_and_o  out  1  flit accepted when high with link_v_i.
- pr_hdr_o  out  pr_hdr_width_p  protocol header; stable for the whole packet.
- pr_data_o  out  pr_data_width_p  data beat.
- pr_v_o  out  1  beat valid.
- pr_ready_and_i  in  1  consumer ready.
- pr_last_o  out  1  final beat of packet (header beat if no data).

## Operation
- FSM states: e_hdr (collecting header flits), e_hdr_out (presenting header beat), e_data (streaming data).
- e_hdr: link_ready_and_o=1, pr_v_o=0. Each accepted flit is written into header register slot hdr_cnt_r; hdr_cnt_r increments. On acceptance of flit hdr_len_lp−1: hdr_cnt_r←0; state←e_hdr_out.
- Len is taken from flit 0 at wh_len_offset_p and registered as data_rem_r = len+1−hdr_len_lp, width len_width_p.
- e_hdr_out: pr_v_o=1, link_ready_and_o=0, pr_data_o=0, pr_last_o=(data_rem_r==0). On pr handshake, the next state is e_data if data_rem_r≠0, else e_hdr.
- e_data: pass-through. pr_v_o=link_v_i, link_ready_and_o=pr_ready_and_i, pr_data_o=link_data_i, pr_last_o=(data_rem_r==1). Each handshake decrements data_rem_r. The handshake at data_rem_r==1 returns the FSM to e_hdr.
- pr_hdr_o = hdr_r[wh_pr_hdr_offset_p +: pr_hdr_width_p]. It is held from e_hdr_out until the next packet's header starts loading.
- Malformed len (len+1 < hdr_len_lp) fires a simulation assertion; hardware treats it as a zero-data packet.
- Elaboration errors:
  - flit_width_p ≠ pr_data_width_p.
  - Either width is not a power of 2.
  - cord+len fields do not fit in flit 0.

## Timing
- Reset (async assert, sync deassert): state=e_hdr, counters 0, hdr_r 0. Outputs during reset:
  - pr_v_o=0.
  - pr_last_o=0.
  - pr_hdr_o=0.
  - pr_data_o=0.
  - link_ready_and_o=0 (gated by reset).
- Reset mid-packet discards the partial packet; no beat is emitted for it.
- Header latency: header beat is valid the cycle after the last header flit is accepted.
- Data latency: zero; data is combinational link→pr, with no added register.
- Throughput:
  - 1 flit/cycle in e_hdr and e_data.
  - One bubble per packet on the link side, in e_hdr_out.
  - Back-to-back packets: the first flit of the next header may be accepted in the cycle after the last data handshake.
- pr_v_o never depends on pr_ready_and_i. Valid in e_hdr_out is held until the handshake.
- link_ready_and_o depends combinationally on pr_ready_and_i only in e_data.

## Structure
- Wormhole header struct macro and bp_bedrock_msg_header_s come from bp_common_pkg. No new package types are needed.
- Natural sub-module: bsg_serial_in_parallel_out_full (width flit_width_p, els hdr_len_lp) for header collection. The FSM and data_rem_r counter stay in this module.
- Target size: ~150–200 lines.

## Test plan
Configuration: flit 64, cord 7, len 4, cid 2, pr_hdr 110 (hdr_len_lp=2).
- Header-only packet, len=1 → one pr beat, pr_last_o=1, pr_hdr_o equals bits [122:13] of the sent header.
- len=5 with data flits 0xA..0xD, consumer always ready → header beat, then 4 beats 0xA–0xD, pr_last_o only on 0xD, 7 cycles total.
- Same packet with pr_ready_and_i toggling every other cycle → no loss or duplication; link_ready_and_o mirrors pr_ready_and_i in e_data.
- Two back-to-back packets (len=3, then len=1) with link_v_i always high → correct headers, no inter-packet flit accepted during e_hdr_out.
- reset_n_i asserted after the first data beat of a len=5 packet → outputs 0 immediately; a following clean len=2 packet decodes correctly.
- Random lengths 1–15, random link and pr stalls, 1000 packets against a reference scoreboard → exact match.
